// File: rtl/ndp_gate_pkg.sv
// Shared types for the NDP host-gate requester: FSM state encoding and AXI response codes.
package ndp_gate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_OWN  = 3'd2,
    ST_XFER = 3'd3,
    ST_RESP = 3'd4,
    ST_REL  = 3'd5
  } ndp_gate_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/ndp_sync_bit.sv
// Multi-flop synchroniser for a single level signal from a foreign clock domain.
// The reset value is a parameter so the synchronised output starts in a known safe state.
module ndp_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic aresetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) sync_q <= {STAGES{RST_VAL}};
    else          sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ndp_gate_requester.sv
// NDP-side requester for the host write-channel gate: acquires the channel, issues queued single-beat
// AXI writes to PM, and releases the channel after the command flagged last.
// Optional build macro NDP_GATE_TIMEOUT_EN adds a grant-wait timeout that flags err and backs off.
//
//  state | meaning
//  IDLE  | channel not owned, waiting for a command
//  REQ   | stall_channel raised, waiting for grant
//  OWN   | channel owned, cmd_ready high, waiting for next command
//  XFER  | AW and W in flight
//  RESP  | waiting for the B response
//  REL   | stall_channel dropped, waiting for gate to report host path live again
module ndp_gate_requester
  import ndp_gate_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic                cmd_last,
  output logic                stall_channel,
  input  logic                ndp_not_inuse_in,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  output logic                busy,
  output logic                err,
  input  logic                err_clr
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("ndp_gate_requester: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
  end

  ndp_gate_state_t state_q, state_d;
  logic              not_inuse_sync;
  logic              grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              aw_done_q, w_done_q;
  logic              aw_done_d, w_done_d;
  logic              stall_q;
  logic              err_q;
  logic              err_set;
  logic              tmo_hit;

  ndp_sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_not_inuse (
    .clk     (clk),
    .aresetn (aresetn),
    .d       (ndp_not_inuse_in),
    .q       (not_inuse_sync)
  );

  assign grant = ~not_inuse_sync;

`ifdef NDP_GATE_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  // Down-counter reloaded whenever outside REQ, so every REQ entry starts a full window.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)                tmo_cnt_q <= TMO_LOAD;
    else if (state_q != ST_REQ)  tmo_cnt_q <= TMO_LOAD;
    else if (tmo_cnt_q != '0)    tmo_cnt_q <= tmo_cnt_q - 1'b1;
  end

  assign tmo_hit = (tmo_cnt_q == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_OWN);
  assign m_awvalid = (state_q == ST_XFER) && !aw_done_q;
  assign m_wvalid  = (state_q == ST_XFER) && !w_done_q;
  assign m_bready  = (state_q == ST_RESP);
  assign aw_done_d = aw_done_q | (m_awvalid & m_awready);
  assign w_done_d  = w_done_q  | (m_wvalid  & m_wready);

  // Next-state decode; err_set flags an error response or a grant timeout.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    unique case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_REQ;
      ST_REQ: begin
        if (grant) begin
          state_d = ST_OWN;
        end else if (tmo_hit) begin
          err_set = 1'b1;
          state_d = ST_REL;
        end
      end
      ST_OWN:  if (cmd_valid) state_d = ST_XFER;
      ST_XFER: if (aw_done_d && w_done_d) state_d = ST_RESP;
      ST_RESP: begin
        if (m_bvalid) begin
          err_set = (m_bresp != AXI_RESP_OKAY);
          state_d = last_q ? ST_REL : ST_OWN;
        end
      end
      ST_REL:  if (!grant) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, stall request, per-channel done flags and sticky error.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      stall_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_q   <= (state_d == ST_REQ) || (state_d == ST_OWN) ||
                   (state_d == ST_XFER) || (state_d == ST_RESP);
      aw_done_q <= (state_q == ST_XFER) ? aw_done_d : 1'b0;
      w_done_q  <= (state_q == ST_XFER) ? w_done_d  : 1'b0;
      if (err_clr)      err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
    end
  end

  // Capture the command payload on acceptance; held stable through XFER.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else if (cmd_valid && cmd_ready) begin
      addr_q <= cmd_addr;
      data_q <= cmd_data;
      last_q <= cmd_last;
    end
  end

  assign stall_channel = stall_q;
  assign m_awaddr      = addr_q;
  assign m_wdata       = data_q;
  assign m_wstrb       = '1;
  assign m_wlast       = 1'b1;
  assign busy          = (state_q != ST_IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_ndp_gate_requester.sv
// Self-checking bench for ndp_gate_requester: gate and AXI slave models, a vector table for the
// write batches, and hand sequences for REL, async reset and the grant timeout.
module tb_ndp_gate_requester;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              cmd_last = 1'b0;
  logic              stall_channel;
  logic              ndp_not_inuse_in = 1'b1;
  logic              m_awvalid, m_awready;
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_wvalid, m_wready;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wlast;
  logic              m_bvalid = 1'b0;
  logic              m_bready;
  logic [1:0]        m_bresp = 2'b00;
  logic              busy, err;
  logic              err_clr = 1'b0;

  ndp_gate_requester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_last(cmd_last),
    .stall_channel(stall_channel), .ndp_not_inuse_in(ndp_not_inuse_in),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Host gate model: grants grant_dly cycles after stall rises, releases rel_dly cycles after it drops.
  logic gate_en = 1'b1;
  int   grant_dly = 3;
  int   rel_dly = 0;
  int   gcnt = 0;
  int   rcnt = 0;

  always @(posedge clk) begin
    if (stall_channel && gate_en) begin
      rcnt <= 0;
      if (gcnt >= grant_dly) ndp_not_inuse_in <= 1'b0;
      else gcnt <= gcnt + 1;
    end else if (!stall_channel) begin
      gcnt <= 0;
      if (!ndp_not_inuse_in) begin
        if (rcnt >= rel_dly) ndp_not_inuse_in <= 1'b1;
        else rcnt <= rcnt + 1;
      end
    end
  end

  // AXI slave model with per-channel ready delays and a programmable response code.
  int          aw_dly = 0, w_dly = 0;
  int          aw_cnt = 0, w_cnt = 0;
  logic        aw_seen = 1'b0, w_seen = 1'b0;
  logic [1:0]  cur_bresp = 2'b00;
  int          b_count = 0;
  int          proto_bad = 0;
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];

  assign m_awready = m_awvalid && (aw_cnt >= aw_dly);
  assign m_wready  = m_wvalid  && (w_cnt  >= w_dly);

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
      m_bvalid <= 1'b0; m_bresp <= 2'b00;
    end else begin
      if (m_awvalid && m_awready) begin
        aw_log.push_back(m_awaddr);
        aw_cnt <= 0;
      end else if (m_awvalid) aw_cnt <= aw_cnt + 1;
      if (m_wvalid && m_wready) begin
        w_log.push_back(m_wdata);
        if (m_wstrb != 4'hF || !m_wlast) proto_bad <= proto_bad + 1;
        w_cnt <= 0;
      end else if (m_wvalid) w_cnt <= w_cnt + 1;
      if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0;
        b_count  <= b_count + 1;
      end
      if ((aw_seen || (m_awvalid && m_awready)) && (w_seen || (m_wvalid && m_wready))) begin
        m_bvalid <= 1'b1;
        m_bresp  <= cur_bresp;
        aw_seen  <= 1'b0;
        w_seen   <= 1'b0;
      end else begin
        aw_seen <= aw_seen || (m_awvalid && m_awready);
        w_seen  <= w_seen  || (m_wvalid && m_wready);
      end
    end
  end

  // Present a command and hold it until the DUT accepts it (bounded).
  task automatic handshake(input logic [31:0] a, input logic [31:0] d, input logic l, output logic ok);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_last = l;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_b(input int start, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_count > start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
    logic [1:0]  bresp;
    int          aw_d;
    int          w_d;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];
  int   exp_writes = 0;

  initial begin
    logic ok;
    int   n;
    int   b0;

    vecs[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 2'b00, 0, 0, 1'b0};
    vecs[1] = '{32'h0000_0200, 32'h1111_1111, 1'b0, 2'b00, 0, 2, 1'b0};
    vecs[2] = '{32'h0000_0204, 32'h2222_2222, 1'b0, 2'b00, 0, 2, 1'b0};
    vecs[3] = '{32'h0000_0208, 32'h3333_3333, 1'b1, 2'b00, 0, 2, 1'b0};
    vecs[4] = '{32'h0000_0300, 32'hA5A5_A5A5, 1'b0, 2'b00, 1, 0, 1'b0};
    vecs[5] = '{32'h0000_0304, 32'h5A5A_5A5A, 1'b0, 2'b10, 0, 0, 1'b1};
    vecs[6] = '{32'h0000_0308, 32'h0F0F_0F0F, 1'b1, 2'b00, 1, 1, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({stall_channel, cmd_ready, m_awvalid, m_wvalid, m_bready, busy, err}), 64'd0);
    chk("reset_awaddr", 64'(m_awaddr), 64'd0);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_cmd", 64'({stall_channel, busy}), 64'd0);

    // Table of write batches.
    for (int k = 0; k < 7; k++) begin
      aw_dly = vecs[k].aw_d; w_dly = vecs[k].w_d; cur_bresp = vecs[k].bresp;
      b0 = b_count;
      handshake(vecs[k].addr, vecs[k].data, vecs[k].last, ok);
      chk($sformatf("v%0d_accept", k), 64'(ok), 64'd1);
      wait_b(b0, ok);
      chk($sformatf("v%0d_bresp_done", k), 64'(ok), 64'd1);
      exp_writes++;
      chk($sformatf("v%0d_nwrites", k), 64'(aw_log.size()), 64'(exp_writes));
      if (aw_log.size() == exp_writes && w_log.size() == exp_writes) begin
        chk($sformatf("v%0d_awaddr", k), 64'(aw_log[exp_writes-1]), 64'(vecs[k].addr));
        chk($sformatf("v%0d_wdata", k), 64'(w_log[exp_writes-1]), 64'(vecs[k].data));
      end
      chk($sformatf("v%0d_err", k), 64'(err), 64'(vecs[k].exp_err));
      if (!vecs[k].last) begin
        chk($sformatf("v%0d_stall_held", k), 64'({stall_channel, cmd_ready}), 64'h3);
      end else begin
        chk($sformatf("v%0d_stall_drop", k), 64'(stall_channel), 64'd0);
        wait_idle(ok);
        chk($sformatf("v%0d_idle", k), 64'({ok, busy}), 64'h2);
      end
    end
    chk("proto_wstrb_wlast", 64'(proto_bad), 64'd0);

    // Sticky error cleared by err_clr.
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 64'(err), 64'd0);
    @(negedge clk);
    chk("err_stays_clear", 64'(err), 64'd0);

    // cmd_valid toggling during REL must not be accepted.
    rel_dly = 5; aw_dly = 0; w_dly = 0; cur_bresp = 2'b00;
    b0 = b_count;
    handshake(32'h0000_0400, 32'hCAFE_F00D, 1'b1, ok);
    wait_b(b0, ok);
    exp_writes++;
    chk("rel_first_done", 64'({ok, stall_channel, busy}), 64'h5);
    cmd_addr = 32'h0000_0404; cmd_data = 32'h1234_5678; cmd_last = 1'b1;
    n = 0;
    for (int i = 0; i < 50 && busy; i++) begin
      cmd_valid = ~cmd_valid;
      #1;
      if (cmd_ready) chk("rel_cmd_ready", 64'(cmd_ready), 64'd0);
      n++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("rel_window_seen", 64'(n > 1), 64'd1);
    chk("rel_no_extra_write", 64'(aw_log.size()), 64'(exp_writes));
    rel_dly = 0;
    b0 = b_count;
    handshake(32'h0000_0404, 32'h1234_5678, 1'b1, ok);
    chk("rel_retry_accept", 64'(ok), 64'd1);
    wait_b(b0, ok);
    exp_writes++;
    if (aw_log.size() == exp_writes)
      chk("rel_retry_addr", 64'(aw_log[exp_writes-1]), 64'h404);
    else
      chk("rel_retry_count", 64'(aw_log.size()), 64'(exp_writes));
    wait_idle(ok);

    // Asynchronous reset while AW is pending.
    aw_dly = 20; w_dly = 20;
    handshake(32'h0000_0500, 32'hBADC_0FFE, 1'b1, ok);
    n = 0;
    while (!m_awvalid && n < 20) begin @(negedge clk); n++; end
    chk("xfer_awvalid", 64'(m_awvalid), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({stall_channel, cmd_ready, m_awvalid, m_wvalid, m_bready, busy, err}), 64'd0);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_reset_idle", 64'({busy, m_awvalid, stall_channel}), 64'd0);
    chk("after_reset_no_write", 64'(aw_log.size()), 64'(exp_writes));
    aw_dly = 0; w_dly = 0;
    repeat (5) @(negedge clk);

`ifdef NDP_GATE_TIMEOUT_EN
    // Grant never arrives: timeout after 16 REQ cycles, then retry succeeds.
    gate_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h0000_0600; cmd_data = 32'h0600_0600; cmd_last = 1'b1;
    n = 0;
    while (!stall_channel && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (stall_channel && !err && n < 100) begin @(negedge clk); n++; end
    chk("tmo_req_cycles", 64'(n), 64'd16);
    chk("tmo_err_stall", 64'({err, stall_channel}), 64'h2);
    gate_en = 1'b1;
    b0 = b_count;
    handshake(32'h0000_0600, 32'h0600_0600, 1'b1, ok);
    chk("tmo_retry_accept", 64'(ok), 64'd1);
    wait_b(b0, ok);
    exp_writes++;
    chk("tmo_retry_writes", 64'(aw_log.size()), 64'(exp_writes));
    wait_idle(ok);
`else
    // Without the timeout, REQ waits indefinitely for grant.
    gate_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 32'h0000_0600; cmd_data = 32'h0600_0600; cmd_last = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_tmo_waits", 64'({stall_channel, busy, err, cmd_ready}), 64'hC);
    gate_en = 1'b1;
    b0 = b_count;
    handshake(32'h0000_0600, 32'h0600_0600, 1'b1, ok);
    chk("late_grant_accept", 64'(ok), 64'd1);
    wait_b(b0, ok);
    exp_writes++;
    chk("late_grant_writes", 64'(aw_log.size()), 64'(exp_writes));
    wait_idle(ok);
`endif
    chk("final_idle", 64'({busy, stall_channel}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
